// File: rtl/pe_seq_mac.sv
// Time-multiplexed neuron processing element: one multiplier per output neuron,
// iterated over NEU_IN inputs, followed by a hard-tanh or linear transfer stage.
module pe_seq_mac #(
  parameter int unsigned WORD_LEN = 16,
  parameter int unsigned NEU_IN   = 8,
  parameter int unsigned NEU_OUT  = 4,
  parameter int unsigned W_FRAC   = 12
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 ce,
  input  logic                                 start,
  output logic                                 in_ready,
  input  logic [WORD_LEN*NEU_IN-1:0]           DATA,
  input  logic [WORD_LEN*NEU_IN*NEU_OUT-1:0]   WEIGHT,
  input  logic                                 act_sel,
  output logic [WORD_LEN*NEU_OUT-1:0]          Q,
  output logic [NEU_OUT-1:0]                   sat,
  output logic                                 out_valid
);

  localparam int unsigned IDX_W  = $clog2(NEU_IN);
  localparam int unsigned PROD_W = 2 * WORD_LEN;
  localparam int unsigned ACC_W  = PROD_W + $clog2(NEU_IN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  // Output clip bounds expressed at accumulator width
  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 << (WORD_LEN - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

  logic [1:0]                    state_q, state_d;
  logic [IDX_W-1:0]              idx_q;
  logic                          act_q;
  logic signed [WORD_LEN-1:0]    data_q   [NEU_IN];
  logic signed [WORD_LEN-1:0]    weight_q [NEU_OUT][NEU_IN];
  logic signed [ACC_W-1:0]       acc_q    [NEU_OUT];
  logic signed [PROD_W-1:0]      prod_c   [NEU_OUT];
  logic signed [ACC_W-1:0]       shift_c  [NEU_OUT];
  logic [WORD_LEN*NEU_OUT-1:0]   q_c;
  logic [NEU_OUT-1:0]            sat_c;
  logic                          accept_c;
  logic                          last_c;

  assign in_ready = (state_q == IDLE);
  assign accept_c = ce & start & (state_q == IDLE);
  assign last_c   = (idx_q == IDX_W'(NEU_IN - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (ce) begin
      case (state_q)
        IDLE:    if (start)  state_d = MAC;
        MAC:     if (last_c) state_d = OUT;
        OUT:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Operand capture on accept; inputs are don't-care afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q <= 1'b0;
      for (int unsigned i = 0; i < NEU_IN; i++) begin
        data_q[i] <= '0;
      end
      for (int unsigned j = 0; j < NEU_OUT; j++) begin
        for (int unsigned i = 0; i < NEU_IN; i++) begin
          weight_q[j][i] <= '0;
        end
      end
    end else if (accept_c) begin
      act_q <= act_sel;
      for (int unsigned i = 0; i < NEU_IN; i++) begin
        data_q[i] <= DATA[i*WORD_LEN +: WORD_LEN];
      end
      for (int unsigned j = 0; j < NEU_OUT; j++) begin
        for (int unsigned i = 0; i < NEU_IN; i++) begin
          weight_q[j][i] <= WEIGHT[(j*NEU_IN + i)*WORD_LEN +: WORD_LEN];
        end
      end
    end
  end

  // One signed product per neuron for the current input index
  always_comb begin
    for (int unsigned j = 0; j < NEU_OUT; j++) begin
      prod_c[j] = PROD_W'(data_q[idx_q]) * PROD_W'(weight_q[j][idx_q]);
    end
  end

  // Accumulators and input index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      for (int unsigned j = 0; j < NEU_OUT; j++) begin
        acc_q[j] <= '0;
      end
    end else if (ce) begin
      if (accept_c) begin
        idx_q <= '0;
        for (int unsigned j = 0; j < NEU_OUT; j++) begin
          acc_q[j] <= '0;
        end
      end else if (state_q == MAC) begin
        idx_q <= last_c ? '0 : idx_q + IDX_W'(1);
        for (int unsigned j = 0; j < NEU_OUT; j++) begin
          acc_q[j] <= acc_q[j] + ACC_W'(prod_c[j]);
        end
      end
    end
  end

  // Transfer function: arithmetic shift to output format, then saturate
  always_comb begin
    q_c   = '0;
    sat_c = '0;
    for (int unsigned j = 0; j < NEU_OUT; j++) begin
      shift_c[j] = act_q ? (acc_q[j] >>> (WORD_LEN - 1)) : (acc_q[j] >>> W_FRAC);
      if (shift_c[j] > MAX_V) begin
        q_c[j*WORD_LEN +: WORD_LEN] = MAX_V[WORD_LEN-1:0];
        sat_c[j] = 1'b1;
      end else if (shift_c[j] < MIN_V) begin
        q_c[j*WORD_LEN +: WORD_LEN] = MIN_V[WORD_LEN-1:0];
        sat_c[j] = 1'b1;
      end else begin
        q_c[j*WORD_LEN +: WORD_LEN] = shift_c[j][WORD_LEN-1:0];
      end
    end
  end

  // Result registers; out_valid holds through stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q         <= '0;
      sat       <= '0;
      out_valid <= 1'b0;
    end else if (ce) begin
      out_valid <= (state_q == OUT);
      if (state_q == OUT) begin
        Q   <= q_c;
        sat <= sat_c;
      end
    end
  end

endmodule

// File: tb/tb_pe_seq_mac.sv
// Randomized scoreboard bench for pe_seq_mac against an arithmetic reference model.
module tb_pe_seq_mac;

  localparam int unsigned WL = 16;
  localparam int unsigned NI = 8;
  localparam int unsigned NO = 4;
  localparam int unsigned WF = 12;

  typedef struct {
    logic [WL*NO-1:0] q;
    logic [NO-1:0]    s;
    int               due;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ce = 1'b0;
  logic               start = 1'b0;
  logic               act_sel = 1'b0;
  logic [WL*NI-1:0]    data = '0;
  logic [WL*NI*NO-1:0] weight = '0;
  logic               in_ready;
  logic [WL*NO-1:0]    q;
  logic [NO-1:0]       sat;
  logic               out_valid;

  logic [WL-1:0] cur_d [NI];
  logic [WL-1:0] cur_w [NO][NI];
  logic          cur_act = 1'b0;

  int   errors = 0;
  int   checks = 0;
  int   en_cnt = 0;
  int   busy_until = 0;
  logic prev_ce = 1'b0;
  exp_t sb[$];

  pe_seq_mac #(.WORD_LEN(WL), .NEU_IN(NI), .NEU_OUT(NO), .W_FRAC(WF)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start), .in_ready(in_ready),
    .DATA(data), .WEIGHT(weight), .act_sel(act_sel),
    .Q(q), .sat(sat), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: exact integer dot product, floor shift, clip to signed word range
  task automatic ref_calc(input logic act, output logic [WL*NO-1:0] rq, output logic [NO-1:0] rs);
    longint acc, v;
    rq = '0;
    rs = '0;
    for (int j = 0; j < int'(NO); j++) begin
      acc = 0;
      for (int i = 0; i < int'(NI); i++) begin
        acc += longint'($signed(cur_d[i])) * longint'($signed(cur_w[j][i]));
      end
      v = act ? (acc >>> (WL - 1)) : (acc >>> WF);
      if (v > 32767) begin
        v = 32767;
        rs[j] = 1'b1;
      end else if (v < -32768) begin
        v = -32768;
        rs[j] = 1'b1;
      end
      rq[j*WL +: WL] = v[WL-1:0];
    end
  endtask

  // Model: an accepted request produces its result NI+1 enabled edges later
  always @(posedge clk) begin
    exp_t e;
    if (ce) begin
      if (rst_n && start && en_cnt >= busy_until) begin
        ref_calc(cur_act, e.q, e.s);
        e.due = en_cnt + 1 + int'(NI) + 1;
        sb.push_back(e);
        busy_until = e.due;
      end
      en_cnt++;
    end
  end

  // Monitor: a fresh result is out_valid after an enabled edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && prev_ce) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 (no pending request)");
      end else begin
        e = sb.pop_front();
        chk("Q", 64'(q), 64'(e.q));
        chk("sat", 64'(sat), 64'(e.s));
        chk("result_edge", 64'(en_cnt), 64'(e.due));
      end
    end
    prev_ce = ce;
  end

  task automatic step(input logic st, input logic c);
    start   = st;
    ce      = c;
    act_sel = cur_act;
    for (int i = 0; i < int'(NI); i++) data[i*WL +: WL] = cur_d[i];
    for (int j = 0; j < int'(NO); j++)
      for (int i = 0; i < int'(NI); i++) weight[(j*NI + i)*WL +: WL] = cur_w[j][i];
    if (rst_n) chk("in_ready", 64'(in_ready), 64'(en_cnt >= busy_until));
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [WL-1:0] dv, input logic [WL-1:0] wv);
    for (int i = 0; i < int'(NI); i++) cur_d[i] = dv;
    for (int j = 0; j < int'(NO); j++)
      for (int i = 0; i < int'(NI); i++) cur_w[j][i] = wv;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < int'(NI); i++) cur_d[i] = WL'($urandom);
    for (int j = 0; j < int'(NO); j++)
      for (int i = 0; i < int'(NI); i++)
        cur_w[j][i] = ($urandom_range(0, 3) == 0) ? WL'($urandom)
                                                 : WL'($urandom_range(0, 2047)) - WL'(1024);
  endtask

  task automatic run_txn(input logic act);
    cur_act = act;
    step(1'b1, 1'b1);
    repeat (NI + 1) step(1'b0, 1'b1);
  endtask

  initial begin
    set_all('0, '0);
    @(posedge clk);
    #1;
    chk("reset_Q", 64'(q), 64'd0);
    chk("reset_sat", 64'(sat), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    step(1'b0, 1'b1);

    set_all(16'h4000, 16'h1000);
    run_txn(1'b0);
    chk("posclip_tanh_Q", 64'(q), {4{16'h7FFF}});
    chk("posclip_tanh_sat", 64'(sat), 64'hF);
    run_txn(1'b1);
    chk("posclip_lin_Q", 64'(q), {4{16'h4000}});

    set_all('0, '0);
    cur_d[0] = 16'h4000;
    cur_w[0][0] = 16'h0800;
    cur_w[1][0] = 16'hF000;
    run_txn(1'b0);
    chk("exact_tanh_Q", 64'(q), {16'h0000, 16'h0000, 16'hC000, 16'h2000});
    run_txn(1'b1);
    chk("exact_lin_Q", 64'(q), {16'h0000, 16'h0000, 16'hF800, 16'h0400});

    set_all(16'h8000, 16'h7FFF);
    run_txn(1'b0);
    run_txn(1'b1);
    chk("negclip_lin_Q", 64'(q), {4{16'h8000}});

    // Stall three cycles at idx 4, then stall while the result is presented
    set_all(16'h4000, 16'h1000);
    cur_act = 1'b0;
    step(1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    step(1'b0, 1'b0);
    chk("stretch_1", 64'(out_valid), 64'd1);
    step(1'b0, 1'b0);
    chk("stretch_2", 64'(out_valid), 64'd1);
    chk("stretch_Q", 64'(q), {4{16'h7FFF}});
    step(1'b0, 1'b1);
    chk("pulse_end", 64'(out_valid), 64'd0);

    // start during MAC with other operands is ignored
    rand_ops();
    cur_act = 1'($urandom);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    rand_ops();
    repeat (2) step(1'b1, 1'b1);
    start = 1'b0;
    repeat (4) step(1'b0, 1'b1);

    // start held high: back-to-back
    repeat (30) begin
      rand_ops();
      step(1'b1, 1'b1);
    end
    repeat (10) step(1'b0, 1'b1);

    repeat (400) begin
      rand_ops();
      cur_act = 1'($urandom);
      step(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0);
    end
    repeat (40) step(1'b0, 1'b1);

    // Asynchronous reset mid-MAC aborts the request
    set_all(16'h4000, 16'h1000);
    run_txn(1'b0);
    step(1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    busy_until = en_cnt;
    #1;
    chk("midreset_Q", 64'(q), 64'd0);
    chk("midreset_sat", 64'(sat), 64'd0);
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) step(1'b0, 1'b1);
    rst_n = 1'b1;
    repeat (15) step(1'b0, 1'b1);

    for (int k = 0; k < 50 && sb.size() != 0; k++) step(1'b0, 1'b1);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
